regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; depth = 2**ADDR_W.
- NRD, 2, number of read ports.
- NWR, 2, number of write ports; higher port index has higher priority.
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- rd_addr  in  NRD*ADDR_W  read addresses, port p at bits [p*ADDR_W +: ADDR_W].
- rd_data  out  NRD*DATA_W  read data, combinational.
- rd_busy  out  NRD  read register has an outstanding producer, combinational.
- wr_en  in  NWR  per-port write enable.
- wr_addr  in  NWR*ADDR_W  write addresses.
- wr_data  in  NWR*DATA_W  write data.
- iss_en  in  1  issue: mark destination as pending.
- iss_addr  in  ADDR_W  issue destination.
- busy_cnt  out  ADDR_W+1  number of busy entries, registered.

Function
REQ-003 Storage SHALL hold 2**ADDR_W entries of DATA_W bits; entry 0 SHALL read as zero and SHALL never be written or marked busy.
REQ-004 On a rising edge, each write port with wr_en=1 and wr_addr!=0 SHALL update its entry.
REQ-005 Two enabled write ports with the same address SHALL store only the data of the highest-index port.
REQ-006 rd_data for port p SHALL be zero when rd_addr=0.
REQ-007 Otherwise, rd_data SHALL be the wr_data of the highest-index enabled write port matching rd_addr in the same cycle (write-through bypass).
REQ-008 Otherwise, rd_data SHALL be the stored entry.
REQ-009 Zero latency: the bypass in REQ-007 SHALL make a same-cycle write visible on every read port.
REQ-010 Scoreboard: busy[a] SHALL be set on the edge where iss_en=1, iss_addr=a, a!=0.
REQ-011 busy[a] SHALL clear on the edge where any enabled write port targets a and no issue to a occurs.
REQ-012 Simultaneous issue and write to the same address SHALL leave busy set, because the new producer supersedes the old one.
REQ-013 Write to a non-busy entry SHALL leave busy clear; no error is flagged.
REQ-014 rd_busy[p] SHALL equal busy[rd_addr_p] AND NOT (any enabled write port matches rd_addr_p); it SHALL be 0 for address 0.
REQ-015 busy_cnt SHALL equal the population count of busy after each edge, range 0..2**ADDR_W-1.

Reset
REQ-016 reset=1 at a rising edge SHALL clear all entries, all busy bits and busy_cnt to 0.
REQ-017 Writes and issues presented in a reset cycle SHALL be discarded.
REQ-018 Reset asserted mid-operation SHALL take priority over every pending write or issue in that cycle.
REQ-019 After reset, every rd_data SHALL be 0 and every rd_busy SHALL be 0, absent same-cycle writes.
REQ-020 Reset SHALL complete in one cycle; the block SHALL accept writes and issues in the following cycle.

Structure
REQ-021 Package regfile_pkg SHALL hold the default DATA_W/ADDR_W/NRD/NWR constants and a popcount function for busy_cnt.
REQ-022 One sub-module rf_read_port SHALL implement the zero/bypass/storage selection and rd_busy for one port.
REQ-023 rf_read_port SHALL be instantiated NRD times by a generate loop.
REQ-024 Storage and scoreboard SHALL remain in regfile_sb.

Verification
REQ-025 After reset: read addrs 0 and 31 -> rd_data=0, rd_busy=0, busy_cnt=0.
REQ-026 Write port0 addr 5 data 0x12345678 while port0 reads 5 -> same-cycle rd_data=0x12345678; next cycle the storage read returns the same value.
REQ-027 Ports 0 and 1 both write addr 7, data 0xAAAA0000 and 0x0000BBBB -> rd_data of 7 = 0x0000BBBB in that cycle and afterwards.
REQ-028 Write addr 0 data 0xFFFFFFFF plus issue addr 0 -> rd_data(0)=0, busy_cnt stays 0.
REQ-029 Scoreboard sequence:
- Issue addr 3 -> rd_busy(3)=1, busy_cnt=1.
- Next: write addr 3 together with issue addr 3 -> busy stays set, busy_cnt=1.
- Next: write addr 3 alone -> rd_busy=0 in that cycle; busy_cnt=0 after the edge.
REQ-030 Issue addr 9 and write addr 9 data 0x55, with reset asserted in the same cycle -> entry 9 = 0, busy_cnt = 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
// Popcount is sized for the largest supported depth; callers zero-extend.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int NRD_DEF    = 2;
    localparam int NWR_DEF    = 2;

    // Widest busy vector the popcount helper accepts (ADDR_W up to 10).
    localparam int POP_MAX_W  = 1024;

    function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] vec);
        int unsigned n;
        n = 0;
        for (int i = 0; i < POP_MAX_W; i++) begin
            n += 32'(vec[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/regfile_sb_read_port.sv
// One read port: zero register, same-cycle write bypass, then stored entry.
// rd_busy is masked when a write in this cycle retires the producer.
module rf_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NWR    = NWR_DEF
) (
    input  logic [ADDR_W-1:0]     rd_addr,
    input  logic [NWR-1:0]        wr_en,
    input  logic [NWR*ADDR_W-1:0] wr_addr,
    input  logic [NWR*DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0]     stored,
    input  logic                  stored_busy,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_busy
);

    logic hit;

    always_comb begin
        rd_data = stored;
        hit     = 1'b0;
        // Ascending scan so the highest-index matching port wins.
        for (int w = 0; w < NWR; w++) begin
            if (wr_en[w] && (wr_addr[w*ADDR_W +: ADDR_W] == rd_addr)) begin
                rd_data = wr_data[w*DATA_W +: DATA_W];
                hit     = 1'b1;
            end
        end
        if (rd_addr == '0) begin
            rd_data = '0;
        end
        rd_busy = stored_busy && !hit && (rd_addr != '0);
    end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with zero-latency write bypass and a busy
// scoreboard tracking registers that still await an issued producer.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NRD    = NRD_DEF,
    parameter int NWR    = NWR_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NRD*ADDR_W-1:0] rd_addr,
    output logic [NRD*DATA_W-1:0] rd_data,
    output logic [NRD-1:0]        rd_busy,
    input  logic [NWR-1:0]        wr_en,
    input  logic [NWR*ADDR_W-1:0] wr_addr,
    input  logic [NWR*DATA_W-1:0] wr_data,
    input  logic                  iss_en,
    input  logic [ADDR_W-1:0]     iss_addr,
    output logic [ADDR_W:0]       busy_cnt
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_next;

    // Issue is applied after writes so a new producer supersedes the old one.
    always_comb begin
        busy_next = busy;
        for (int w = 0; w < NWR; w++) begin
            if (wr_en[w]) begin
                busy_next[wr_addr[w*ADDR_W +: ADDR_W]] = 1'b0;
            end
        end
        if (iss_en) begin
            busy_next[iss_addr] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            for (int w = 0; w < NWR; w++) begin
                if (wr_en[w] && (wr_addr[w*ADDR_W +: ADDR_W] != '0)) begin
                    mem[wr_addr[w*ADDR_W +: ADDR_W]] <= wr_data[w*DATA_W +: DATA_W];
                end
            end
            busy     <= busy_next;
            busy_cnt <= (ADDR_W+1)'(popcount(POP_MAX_W'(busy_next)));
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        assign addr = rd_addr[p*ADDR_W +: ADDR_W];

        rf_read_port #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .NWR    (NWR)
        ) u_port (
            .rd_addr     (addr),
            .wr_en       (wr_en),
            .wr_addr     (wr_addr),
            .wr_data     (wr_data),
            .stored      (mem[addr]),
            .stored_busy (busy[addr]),
            .rd_data     (rd_data[p*DATA_W +: DATA_W]),
            .rd_busy     (rd_busy[p])
        );
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed vector table, then a randomized phase
// checked against a behavioural model; busy_cnt goes through a queue.
module tb_regfile_sb;

    logic        clk;
    logic        reset;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic [5:0]  busy_cnt;

    regfile_sb dut (
        .clk      (clk),
        .reset    (reset),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .busy_cnt (busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        ie;
        logic [4:0]  ia;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] ed0;
        logic [31:0] ed1;
        logic [1:0]  eb;
        logic [5:0]  ecnt;
    } vec_t;

    vec_t       vecs[$];
    logic [5:0] cnt_q[$];
    int         n_vec  = 0;
    int         n_miss = 0;

    logic [31:0] mdl_mem [32];
    logic [31:0] mdl_busy;

    function automatic vec_t mk(input logic rst, input logic [1:0] we,
                                input logic [4:0] wa0, input logic [31:0] wd0,
                                input logic [4:0] wa1, input logic [31:0] wd1,
                                input logic ie, input logic [4:0] ia,
                                input logic [4:0] ra0, input logic [4:0] ra1,
                                input logic [31:0] ed0, input logic [31:0] ed1,
                                input logic [1:0] eb, input logic [5:0] ecnt);
        vec_t v;
        v.rst = rst; v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
        v.ie = ie; v.ia = ia; v.ra0 = ra0; v.ra1 = ra1;
        v.ed0 = ed0; v.ed1 = ed1; v.eb = eb; v.ecnt = ecnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset    = v.rst;
        wr_en    = v.we;
        wr_addr  = {v.wa1, v.wa0};
        wr_data  = {v.wd1, v.wd0};
        iss_en   = v.ie;
        iss_addr = v.ia;
        rd_addr  = {v.ra1, v.ra0};
    endtask

    // Drives a vector, checks combinational outputs, then the registered count.
    task automatic apply(input vec_t v, input string tag);
        logic [5:0] exp_cnt;
        drive(v);
        #2;
        chk({tag, " rd_data0"}, rd_data[31:0], v.ed0);
        chk({tag, " rd_data1"}, rd_data[63:32], v.ed1);
        chk({tag, " rd_busy"}, 32'(rd_busy), 32'(v.eb));
        cnt_q.push_back(v.ecnt);
        @(posedge clk);
        #1;
        if (cnt_q.size() == 0) begin
            chk({tag, " busy_cnt queue"}, 32'(busy_cnt), 32'hDEAD_BEEF);
        end else begin
            exp_cnt = cnt_q.pop_front();
            chk({tag, " busy_cnt"}, 32'(busy_cnt), 32'(exp_cnt));
        end
    endtask

    // Fills the vector's expectations from the model and advances the model.
    task automatic model_step(inout vec_t v);
        logic [4:0]  ra [2];
        logic [31:0] d;
        logic        hit;
        int          cnt;
        ra[0] = v.ra0;
        ra[1] = v.ra1;
        for (int p = 0; p < 2; p++) begin
            d   = mdl_mem[ra[p]];
            hit = 1'b0;
            if (v.we[0] && v.wa0 == ra[p]) begin d = v.wd0; hit = 1'b1; end
            if (v.we[1] && v.wa1 == ra[p]) begin d = v.wd1; hit = 1'b1; end
            if (ra[p] == 5'd0) d = '0;
            if (p == 0) v.ed0 = d; else v.ed1 = d;
            v.eb[p] = (ra[p] != 5'd0) && mdl_busy[ra[p]] && !hit;
        end
        if (v.rst) begin
            for (int i = 0; i < 32; i++) mdl_mem[i] = '0;
            mdl_busy = '0;
        end else begin
            if (v.we[0] && v.wa0 != 5'd0) begin mdl_mem[v.wa0] = v.wd0; mdl_busy[v.wa0] = 1'b0; end
            if (v.we[1] && v.wa1 != 5'd0) begin mdl_mem[v.wa1] = v.wd1; mdl_busy[v.wa1] = 1'b0; end
            if (v.ie && v.ia != 5'd0) mdl_busy[v.ia] = 1'b1;
        end
        cnt = 0;
        for (int i = 0; i < 32; i++) cnt += 32'(mdl_busy[i]);
        v.ecnt = 6'(cnt);
    endtask

    initial begin
        vec_t v;
        drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;

        //           rst we   wa0  wd0           wa1  wd1           ie ia  ra0  ra1  ed0           ed1           eb     cnt
        vecs.push_back(mk(0, 2'b00, 0, 0,            0, 0,            0, 0, 0,   31, 0,            0,            2'b00, 0));
        vecs.push_back(mk(0, 2'b01, 5, 32'h12345678, 0, 0,            0, 0, 5,   0,  32'h12345678, 0,            2'b00, 0));
        vecs.push_back(mk(0, 2'b00, 0, 0,            0, 0,            0, 0, 5,   5,  32'h12345678, 32'h12345678, 2'b00, 0));
        vecs.push_back(mk(0, 2'b11, 7, 32'hAAAA0000, 7, 32'h0000BBBB, 0, 0, 7,   7,  32'h0000BBBB, 32'h0000BBBB, 2'b00, 0));
        vecs.push_back(mk(0, 2'b00, 0, 0,            0, 0,            0, 0, 7,   5,  32'h0000BBBB, 32'h12345678, 2'b00, 0));
        vecs.push_back(mk(0, 2'b01, 0, 32'hFFFFFFFF, 0, 0,            1, 0, 0,   0,  0,            0,            2'b00, 0));
        vecs.push_back(mk(0, 2'b00, 0, 0,            0, 0,            1, 3, 3,   0,  0,            0,            2'b00, 1));
        vecs.push_back(mk(0, 2'b00, 0, 0,            0, 0,            0, 0, 3,   0,  0,            0,            2'b01, 1));
        vecs.push_back(mk(0, 2'b10, 0, 0,            3, 32'h0000C0DE, 1, 3, 3,   3,  32'h0000C0DE, 32'h0000C0DE, 2'b00, 1));
        vecs.push_back(mk(0, 2'b00, 0, 0,            0, 0,            0, 0, 3,   3,  32'h0000C0DE, 32'h0000C0DE, 2'b11, 1));
        vecs.push_back(mk(0, 2'b01, 3, 32'h0000D00D, 0, 0,            0, 0, 3,   3,  32'h0000D00D, 32'h0000D00D, 2'b00, 0));
        vecs.push_back(mk(0, 2'b00, 0, 0,            0, 0,            0, 0, 3,   3,  32'h0000D00D, 32'h0000D00D, 2'b00, 0));
        vecs.push_back(mk(0, 2'b01, 12, 32'h1,       0, 0,            0, 0, 12,  0,  32'h1,        0,            2'b00, 0));
        vecs.push_back(mk(0, 2'b00, 0, 0,            0, 0,            1, 9, 9,   20, 0,            0,            2'b00, 1));
        vecs.push_back(mk(0, 2'b00, 0, 0,            0, 0,            1, 20, 9,  20, 0,            0,            2'b01, 2));
        vecs.push_back(mk(1, 2'b01, 9, 32'h55,       0, 0,            1, 9, 9,   20, 32'h55,       0,            2'b10, 0));
        vecs.push_back(mk(0, 2'b00, 0, 0,            0, 0,            0, 0, 9,   20, 0,            0,            2'b00, 0));
        vecs.push_back(mk(0, 2'b01, 5, 32'h777,      0, 0,            1, 9, 5,   7,  32'h777,      0,            2'b00, 1));
        vecs.push_back(mk(0, 2'b00, 0, 0,            0, 0,            0, 0, 9,   5,  0,            32'h777,      2'b01, 1));
        vecs.push_back(mk(0, 2'b00, 0, 0,            0, 0,            0, 0, 12,  3,  0,            0,            2'b00, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        v = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_step(v);
        apply(v, "rand_reset");
        for (int i = 0; i < 400; i++) begin
            v.rst = ($urandom_range(0, 47) == 0);
            v.we  = 2'($urandom_range(0, 3));
            v.wa0 = 5'($urandom_range(0, 7));
            v.wa1 = ($urandom_range(0, 3) == 0) ? v.wa0 : 5'($urandom_range(0, 7));
            v.wd0 = $urandom;
            v.wd1 = $urandom;
            v.ie  = ($urandom_range(0, 1) == 1);
            v.ia  = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            v.ra0 = 5'($urandom_range(0, 7));
            v.ra1 = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            model_step(v);
            apply(v, $sformatf("rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
